// File: rtl/mem_sweeper_pkg.sv
// Shared types and helpers for the memory sweeper.
//   state_e   : sequencer states
//   MODE_*    : values of the mode input
//   pattern() : deterministic write data for a word index
//   sat_inc() : 16-bit saturating increment for the error counter
package mem_sweeper_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_RD_REQ, S_GAP, S_DWELL, S_DONE
  } state_e;

  localparam logic MODE_READ_LOOP = 1'b0;
  localparam logic MODE_VERIFY    = 1'b1;

  // Pattern math is done wide; callers truncate to their data width.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] idx);
    return seed + idx;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_sweeper_if.sv
// Valid/ready memory bus between the sweeper (master) and a memory (slave).
//   mem_valid/mem_ready : request handshake, completes when both are high
//   mem_addr            : byte address
//   mem_wdata/mem_wstrb : write data and byte enables (wstrb==0 means read)
//   mem_rdata           : read data, valid with mem_ready
interface mem_sweeper_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_sweeper_txn.sv
// Single-transaction bus engine.
//   issue_i + addr/wdata/wstrb : launch a request (only while no request is open)
//   cpl_o : mem_ready seen on an open request (same cycle as the handshake)
//   tmo_o : request open TIMEOUT_CYCLES cycles without mem_ready
//   bus   : master side of the memory bus; request fields are registered and
//           stay stable until the request closes.
module mem_sweeper_txn #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                cpl_o,
  output logic                tmo_o,
  mem_sweeper_if.master       bus
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    // ready on the last allowed cycle still counts as success
    cpl_o   = valid_q & bus.mem_ready;
    tmo_o   = valid_q & ~bus.mem_ready & (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    if (issue_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      wstrb_d = wstrb_i;
      cnt_d   = '0;
    end else if (cpl_o || tmo_o) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: rtl/mem_sweeper.sv
// Memory exerciser: read-loop (endless scan with dwell for LED display) or
// write-verify (write pattern, read back, count mismatches).
//   start/mode/stop : run control (mode sampled on accepted start)
//   bus             : memory bus master
//   busy/done/error/timeout/err_count : run status (flags sticky per run)
//   cur_index       : word index of current or last transaction
//   display         : low byte of the last completed read
module mem_sweeper
  import mem_sweeper_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int              NUM_WORDS      = 10,
  parameter int              DWELL_TICKS    = 2_500_000,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]     SEED           = 32'hA5A5_0000,
  localparam int             IDX_W          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  mem_sweeper_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             timeout,
  output logic [15:0]      err_count,
  output logic [IDX_W-1:0] cur_index,
  output logic [7:0]       display
);
  localparam int               STRB_W  = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_WORDS - 1);
  localparam int               DW_W    = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW_W-1:0]  DW_LOAD = DW_W'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx, iss_idx;
  logic             mode_q, mode_d, rd_phase_q, rd_phase_d, stop_pend_q, stop_pend_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d, timeout_q, timeout_d;
  logic [15:0]      errc_q, errc_d;
  logic [7:0]       disp_q, disp_d;
  logic             issue, iss_wr, cpl, tmo;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic [STRB_W-1:0] iss_wstrb;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    rd_phase_d  = rd_phase_q;
    stop_pend_d = stop_pend_q;
    dwell_d     = dwell_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    errc_d      = errc_q;
    disp_d      = disp_q;
    issue       = 1'b0;
    iss_wr      = 1'b0;
    iss_idx     = idx_q;
    nxt_idx     = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        mode_d      = mode;
        rd_phase_d  = (mode == MODE_READ_LOOP);
        stop_pend_d = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
        timeout_d   = 1'b0;
        errc_d      = '0;
        issue       = 1'b1;
        iss_wr      = (mode == MODE_VERIFY);
        iss_idx     = '0;
      end
      S_WR_REQ, S_RD_REQ: begin
        // stop only takes effect once the open read has completed
        if (mode_q == MODE_READ_LOOP && stop) stop_pend_d = 1'b1;
        if (cpl) begin
          state_d = S_GAP;
          if (state_q == S_RD_REQ) begin
            disp_d = bus.mem_rdata[7:0];
            if (mode_q == MODE_VERIFY) begin
              if (bus.mem_rdata != DATA_W'(pattern(PAT_W'(SEED), PAT_W'(idx_q)))) begin
                error_d = 1'b1;
                errc_d  = sat_inc(errc_q);
              end
              if (idx_q == LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end
            end else if (stop || stop_pend_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else if (DWELL_TICKS > 0) begin
              state_d = S_DWELL;
              dwell_d = DW_LOAD;
            end
          end
        end else if (tmo) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (mode_q == MODE_READ_LOOP) begin
          if (stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            issue   = 1'b1;
            iss_idx = nxt_idx;
          end
        end else if (!rd_phase_q && idx_q == LAST) begin
          // writes finished: restart the index for the read-back pass
          rd_phase_d = 1'b1;
          issue      = 1'b1;
          iss_idx    = '0;
        end else begin
          issue   = 1'b1;
          iss_wr  = ~rd_phase_q;
          iss_idx = nxt_idx;
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (dwell_q == '0) begin
          issue   = 1'b1;
          iss_idx = nxt_idx;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      idx_d   = iss_idx;
      state_d = iss_wr ? S_WR_REQ : S_RD_REQ;
    end
    iss_addr  = BASE_ADDR + (ADDR_W'(iss_idx) << 2);
    iss_wdata = iss_wr ? DATA_W'(pattern(PAT_W'(SEED), PAT_W'(iss_idx))) : '0;
    iss_wstrb = iss_wr ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      rd_phase_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      errc_q      <= '0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      rd_phase_q  <= rd_phase_d;
      stop_pend_q <= stop_pend_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      errc_q      <= errc_d;
      disp_q      <= disp_d;
    end
  end

  mem_sweeper_txn #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .clk     (clk),
    .reset_n (reset_n),
    .issue_i (issue),
    .addr_i  (iss_addr),
    .wdata_i (iss_wdata),
    .wstrb_i (iss_wstrb),
    .cpl_o   (cpl),
    .tmo_o   (tmo),
    .bus     (bus)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign timeout   = timeout_q;
  assign err_count = errc_q;
  assign cur_index = idx_q;
  assign display   = disp_q;

endmodule

// File: doc/mem_sweeper.md
Name: mem_sweeper

Overview:
- Parametrised memory exerciser that masters the valid/ready memory bus of bram_controller.
- Two modes:
  - Read-loop: scan NUM_WORDS words endlessly, pausing DWELL_TICKS cycles after each read so the read data can be shown on LEDs.
  - Write-verify: write a deterministic pattern to every word, read each word back, compare, and report errors.
- Sits between a board top level (buttons/LEDs) and bram_controller. It is the reusable replacement for hand-coded step machines in top-level test logic.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width (multiple of 8).
- BASE_ADDR, 0, byte address of word 0.
- NUM_WORDS, 10, words swept; must be >= 1.
- DWELL_TICKS, 2_500_000, idle cycles after each read in read-loop mode; 0 = no dwell.
- TIMEOUT_CYCLES, 1024, maximum cycles mem_valid may stay high without mem_ready.
- SEED, 32'hA5A5_0000, pattern base value.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; ignored unless idle or done.
- mode  in  1  0 = read-loop, 1 = write-verify; sampled on an accepted start.
- stop  in  1  end read-loop at the next safe point.
- mem_valid  out  1  request valid.
- mem_ready  in  1  request complete.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  byte enables; all ones = write, 0 = read.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- busy  out  1  run in progress.
- done  out  1  write-verify finished or timeout; held until next start.
- error  out  1  sticky, at least one mismatch.
- timeout  out  1  sticky, bus hang detected.
- err_count  out  16  mismatches, saturates at 16'hFFFF.
- cur_index  out  IDX_W  word index of current or last transaction.
- display  out  8  mem_rdata[7:0] of the last completed read.

Behaviour:
- Widths and arithmetic:
  - IDX_W = max(1, $clog2(NUM_WORDS)).
  - Address = BASE_ADDR + (idx << 2), truncated to ADDR_W.
  - pattern(idx) = SEED + idx, truncated to DATA_W.
- Reset: sampled on clk edges only. When reset_n=0, all outputs go to 0 and the state goes to IDLE, including mid-transaction (mem_valid drops at that edge).
- States: IDLE, WR_REQ, RD_REQ, GAP, DWELL, DONE.
- IDLE / DONE:
  - start=1 latches mode, clears error, timeout, err_count and done, sets idx=0 and busy=1.
  - Next state is WR_REQ (verify) or RD_REQ (read-loop).
- WR_REQ / RD_REQ:
  - mem_valid=1; addr, wdata and wstrb are driven from registers and held stable until mem_ready.
  - In RD_REQ, mem_wdata=0 and mem_wstrb=0.
  - When mem_ready is sampled high, mem_valid=0 on the next cycle.
  - A read captures display; in verify mode it also compares mem_rdata with pattern(idx). On mismatch, error=1 and err_count increments (saturating).
- GAP: one cycle with mem_valid=0 between back-to-back transactions.
- Verify sequencing:
  - Writes run idx 0..NUM_WORDS-1, then idx resets to 0 and reads run over the same range.
  - After the last read: DONE, done=1, busy=0.
- Read-loop sequencing:
  - After each read, go to DWELL for exactly DWELL_TICKS cycles (DWELL_TICKS=0 goes to GAP instead).
  - Then issue RD_REQ for idx+1; idx wraps from NUM_WORDS-1 to 0.
  - Exactly NUM_WORDS distinct addresses per lap.
- stop:
  - Outstanding request: wait for mem_ready, complete the capture, then go to IDLE with busy=0. A request is never abandoned.
  - In DWELL or GAP: go to IDLE on the next edge.
  - Ignored in verify mode.
- Timeout: a counter runs while mem_valid=1.
  - If it reaches TIMEOUT_CYCLES without mem_ready, the next cycle has mem_valid=0, timeout=1, done=1, busy=0, state DONE.
  - mem_ready arriving in the same cycle as expiry counts as success.
- Simultaneous events: start while busy is ignored; start and stop together in IDLE means start wins.

Decomposition:
- Package mem_sweeper_pkg:
  - state enum.
  - MODE_READ_LOOP / MODE_VERIFY constants.
  - pattern function.
  - saturating-increment function.
- Sub-module mem_sweeper_txn: holds request registers stable, drives mem_valid, generates the completion pulse and runs the timeout counter. The sequencer FSM stays in mem_sweeper.

Test Plan:
All scenarios use NUM_WORDS=4, BASE_ADDR=0x100, DWELL_TICKS=3, TIMEOUT_CYCLES=16, and a memory model with 1-cycle ready.
- Verify pass:
  - Stimulus: start with mode=1.
  - Required: writes to 0x100/104/108/10C with data A5A50000..A5A50003 and wstrb=F, then 4 reads with wstrb=0.
  - End state: done=1, error=0, err_count=0, display=0x03.
- Verify fail:
  - Stimulus: the model flips bit 0 of the word at 0x108 on read.
  - Required: err_count=1, error=1, done=1; the other words compare clean.
- Read-loop:
  - Stimulus: start with mode=0.
  - Required: addresses 0x100,104,108,10C,100,...; exactly 3 cycles of mem_valid=0 between ready and the next valid; display tracks the low byte of each read.
  - Then: stop during DWELL gives busy=0 on the next edge.
- Stop with an outstanding request:
  - Stimulus: assert stop while mem_valid=1 and ready is delayed 5 cycles.
  - Required: mem_valid stays high with a stable address until ready, then busy=0.
- Timeout:
  - Stimulus: the model never asserts ready.
  - Required: mem_valid falls 16 cycles after rising; timeout=1, done=1.
  - Then: a new start clears both flags.
- Reset mid-run:
  - Stimulus: reset_n=0 for 1 cycle while mem_valid=1.
  - Required: all outputs 0 at that edge; start is ignored while reset_n=0.
